frame_scheduler: RTL and testbench

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/ledstrip_pkg.sv | 40 ++++
 rtl/refresh_timer.sv | 56 +++++
 rtl/frame_scheduler.sv | 129 ++++++++++++
 tb/tb_frame_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledstrip_pkg.sv
// ============================================================================
// Module   : ledstrip_pkg
// Brief    : Shared pixel width, scheduler state encoding and dimming helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ledstrip_pkg;

  localparam int c_PIX_W = 24;

  localparam logic [2:0] c_ST_IDLE         = 3'd0;
  localparam logic [2:0] c_ST_FETCH        = 3'd1;
  localparam logic [2:0] c_ST_CAPTURE      = 3'd2;
  localparam logic [2:0] c_ST_WAIT_READY   = 3'd3;
  localparam logic [2:0] c_ST_WAIT_STARTED = 3'd4;

  typedef enum logic [2:0] {
    IDLE         = c_ST_IDLE,
    FETCH        = c_ST_FETCH,
    CAPTURE      = c_ST_CAPTURE,
    WAIT_READY   = c_ST_WAIT_READY,
    WAIT_STARTED = c_ST_WAIT_STARTED
  } state_e;

  // Each GRB channel is shifted on its own so no bits bleed between channels.
  function automatic logic [c_PIX_W-1:0] dim_pixel(input logic [c_PIX_W-1:0] px,
                                                   input logic [1:0]         shift);
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
    g = px[23:16] >> shift;
    r = px[15:8]  >> shift;
    b = px[7:0]   >> shift;
    return {g, r, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/refresh_timer.sv
// ============================================================================
// Module   : refresh_timer
// Brief    : Periodic frame trigger counter with a one-deep pending flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module refresh_timer #(
  parameter int REFRESH_DIV = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic force_i,
  input  logic consume_i,
  output logic pending_o
);

  localparam int              c_TW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(REFRESH_DIV - 1);

  logic [c_TW-1:0] timer_q, timer_d;
  logic            pending_q, pending_d;
  logic            w_wrap;

  always_comb begin
    w_wrap    = enable_i && (timer_q == c_TMAX);
    timer_d   = '0;
    if (enable_i && !w_wrap) begin
      timer_d = timer_q + 1'b1;
    end
    pending_d = pending_q;
    if (consume_i) begin
      pending_d = 1'b0;
    end
    // A new trigger in the consume cycle wins so it is not lost.
    if (w_wrap || force_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

`default_nettype wire

// File: rtl/frame_scheduler.sv
// ============================================================================
// Module   : frame_scheduler
// Brief    : Fetches NUM_LEDS pixels per frame and hands them to a strip driver.
//            Define FRAME_SCHEDULER_BRIGHTNESS_EN to enable per-channel dimming.
// Revision : 1.0
// ============================================================================
`default_nettype none

module frame_scheduler
  import ledstrip_pkg::*;
#(
  parameter int NUM_LEDS    = 140,
  parameter int REFRESH_DIV = 65536
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        force_refresh,
  output logic                        pix_req,
  output logic [$clog2(NUM_LEDS)-1:0] pix_addr,
  input  logic [c_PIX_W-1:0]          pix_data,
  output logic [c_PIX_W-1:0]          led_data,
  output logic                        led_valid,
  output logic                        led_latch,
  input  logic                        led_ready,
  input  logic [1:0]                  brightness,
  output logic                        frame_busy,
  output logic                        frame_done
);

  localparam int              c_AW   = $clog2(NUM_LEDS);
  localparam logic [c_AW-1:0] c_LAST = c_AW'(NUM_LEDS - 1);

  state_e             state_q, state_d;
  logic [c_AW-1:0]    idx_q, idx_d;
  logic [c_PIX_W-1:0] led_data_q, led_data_d;
  logic               done_q, done_d;
  logic               w_pending;
  logic               w_consume;
  logic [c_PIX_W-1:0] w_pix_word;

  refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_refresh_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_i  (enable),
    .force_i   (force_refresh),
    .consume_i (w_consume),
    .pending_o (w_pending)
  );

`ifdef FRAME_SCHEDULER_BRIGHTNESS_EN
  assign w_pix_word = dim_pixel(pix_data, brightness);
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^brightness;
  assign w_pix_word          = pix_data;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    led_data_d = led_data_q;
    done_d     = 1'b0;
    w_consume  = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_pending) begin
          w_consume = 1'b1;
          idx_d     = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        led_data_d = w_pix_word;
        state_d    = WAIT_READY;
      end
      WAIT_READY: begin
        if (led_ready) begin
          state_d = WAIT_STARTED;
        end
      end
      WAIT_STARTED: begin
        // Driver dropping ready means it has taken the word.
        if (!led_ready) begin
          if (idx_q == c_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      led_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      led_data_q <= led_data_d;
      done_q     <= done_d;
    end
  end

  assign pix_req    = (state_q == FETCH);
  assign pix_addr   = idx_q;
  assign led_data   = led_data_q;
  assign led_valid  = (state_q == WAIT_STARTED);
  assign led_latch  = led_valid && (idx_q == c_LAST);
  assign frame_busy = (state_q != IDLE);
  assign frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_scheduler.sv
// ============================================================================
// Module   : tb_frame_scheduler
// Brief    : Randomized scoreboard bench for frame_scheduler (NUM_LEDS=4, REFRESH_DIV=16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_frame_scheduler;

  localparam int N   = 4;
  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        force_refresh = 1'b0;
  logic        led_ready = 1'b1;
  logic [1:0]  brightness = 2'd0;
  logic [23:0] pix_data = '0;
  logic        pix_req;
  logic [1:0]  pix_addr;
  logic [23:0] led_data;
  logic        led_valid, led_latch, frame_busy, frame_done;

  frame_scheduler #(.NUM_LEDS(N), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .force_refresh(force_refresh),
    .pix_req(pix_req), .pix_addr(pix_addr), .pix_data(pix_data),
    .led_data(led_data), .led_valid(led_valid), .led_latch(led_latch),
    .led_ready(led_ready), .brightness(brightness),
    .frame_busy(frame_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic        latch;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] mem [N];
  int          checks = 0, errors = 0;
  int          cyc = 0, req_cnt = 0, done_cnt = 0, b2b = 0;
  int          last_done_cyc = -10, first_req_cyc = -1;
  int          exp_addr = 0;
  int          accept_delay = 3;
  bit          hold_low = 1'b0;
  logic [23:0] last_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each channel divided by 2**brightness when dimming is built in.
  function automatic logic [23:0] model_word(input logic [23:0] px, input logic [1:0] b);
    int div;
    div = 1;
`ifdef FRAME_SCHEDULER_BRIGHTNESS_EN
    div = 1 << b;
`else
    div = div + 0 * int'(b);
`endif
    return {8'(int'(px[23:16]) / div), 8'(int'(px[15:8]) / div), 8'(int'(px[7:0]) / div)};
  endfunction

  task automatic push_frame();
    for (int i = 0; i < N; i++) sb.push_back('{model_word(mem[i], brightness), (i == N - 1)});
  endtask

  task automatic fill_mem(input bit rnd, input logic [23:0] val);
    for (int i = 0; i < N; i++) mem[i] = rnd ? 24'($urandom) : val;
  endtask

  task automatic pulse_force();
    @(negedge clk); force_refresh = 1'b1;
    @(negedge clk); force_refresh = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL frame_done_timeout: got %0d frames expected %0d", done_cnt, target);
    end
  endtask

  task automatic wait_req(input int target, input int budget);
    int n = 0;
    while (req_cnt < target && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (req_cnt < target) begin
      errors++;
      $display("FAIL pix_req_timeout: got %0d requests expected %0d", req_cnt, target);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix_req"},    pix_req,    0);
    chk({tag, "_pix_addr"},   pix_addr,   0);
    chk({tag, "_led_valid"},  led_valid,  0);
    chk({tag, "_led_latch"},  led_latch,  0);
    chk({tag, "_frame_busy"}, frame_busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_led_data"},   led_data,   0);
  endtask

  // Pixel memory with one-cycle latency, address sequence and frame_done tracking.
  initial forever begin
    @(negedge clk);
    if (rst_n && pix_req) begin
      chk("pix_addr_seq", pix_addr, exp_addr);
      pix_data = mem[pix_addr];
      if (last_done_cyc == cyc - 1) b2b++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      req_cnt++;
      exp_addr = (exp_addr + 1) % N;
    end
    if (rst_n && frame_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (led_latch) chk("latch_qualified", {31'd0, led_valid && (pix_addr == 2'(N - 1))}, 1);
  end

  // Strip driver model and scoreboard monitor.
  initial begin
    int   busy;
    exp_t e;
    busy = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        led_ready = 1'b1;
        busy = 0;
      end else if (led_valid && led_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0h with nothing expected", led_data);
        end else begin
          e = sb.pop_front();
          chk("led_data", led_data, e.data);
          chk("led_latch", led_latch, e.latch);
        end
        last_word = led_data;
        led_ready = 1'b0;
        busy = accept_delay;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) led_ready = !hold_low;
      end else begin
        led_ready = !hold_low;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rel, found, req_before;
    fill_mem(1'b1, '0);
    idle(3);
    chk_zero("reset");

    // Periodic trigger: one frame, then timer disabled.
    push_frame();
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1; rel = cyc;
    wait_req(1, 100);
    enable = 1'b0;
    chk("first_req_latency", {31'd0, (first_req_cyc - rel) >= 16 && (first_req_cyc - rel) <= 17}, 1);
    wait_done(1, 400);
    idle(40);
    chk("t1_frames", done_cnt, 1);
    chk("t1_reqs", req_cnt, 4);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_idle_busy", frame_busy, 0);

    // Forced frame with a fixed pixel.
    fill_mem(1'b0, 24'h112233);
    push_frame();
    pulse_force();
    wait_done(2, 400);
    idle(60);
    chk("t2_word", last_word, 24'h112233);
    chk("t2_frames", done_cnt, 2);
    chk("t2_reqs", req_cnt, 8);
    chk("t2_sb_empty", sb.size(), 0);

    // Triggers during a frame merge into exactly one follow-on frame.
    fill_mem(1'b1, '0);
    push_frame(); push_frame();
    pulse_force();
    wait_req(9, 100);
    repeat (3) begin pulse_force(); idle(2); end
    wait_done(4, 800);
    idle(60);
    chk("t3_frames", done_cnt, 4);
    chk("t3_reqs", req_cnt, 16);
    chk("t3_back_to_back", b2b, 1);
    chk("t3_sb_empty", sb.size(), 0);

    // Driver stalls: nothing advances while ready is low.
    hold_low = 1'b1;
    push_frame();
    pulse_force();
    wait_req(17, 100);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("t4_valid_low", led_valid, 0);
      chk("t4_busy", frame_busy, 1);
      chk("t4_no_req", req_cnt, 17);
    end
    hold_low = 1'b0;
    wait_done(5, 400);
    idle(10);
    chk("t4_sb_empty", sb.size(), 0);

    // Asynchronous reset mid-frame.
    push_frame();
    pulse_force();
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk);
      if (led_valid && pix_addr == 2'd2) found = 1;
    end
    chk("t5_reached_idx2", found, 1);
    #1 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    sb.delete();
    exp_addr = 0;
    req_before = req_cnt;
    idle(3);
    rst_n = 1'b1;
    idle(60);
    chk("t5_no_resume", req_cnt, req_before);
    chk("t5_idle", frame_busy, 0);

    // Randomized frames: brightness, pixels and accept delay.
    for (int f = 0; f < 4; f++) begin
      brightness = 2'($urandom_range(0, 3));
      accept_delay = $urandom_range(1, 4);
      fill_mem(1'b1, '0);
      push_frame();
      pulse_force();
      wait_done(done_cnt + 1, 400);
      idle(5);
    end
    chk("t6_sb_empty", sb.size(), 0);

    // Fixed dimming example.
    accept_delay = 3;
    brightness = 2'd2;
    fill_mem(1'b0, 24'hFF8040);
    push_frame();
    pulse_force();
    wait_done(done_cnt + 1, 400);
    idle(5);
`ifdef FRAME_SCHEDULER_BRIGHTNESS_EN
    chk("dim_word", last_word, 24'h3F2010);
`else
    chk("dim_word", last_word, 24'hFF8040);
`endif
    chk("t7_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
